// File: rtl/find_bw_pkg.sv
// Shared types and default widths for the bandwidth left-edge search.
package find_bw_pkg;

    localparam int unsigned DefAccumWidth   = 18;
    localparam int unsigned DefFreqBinWidth = 16;
    localparam int unsigned DefNumAccums    = 24;

    typedef enum logic [1:0] {
        StIdle,
        StFindPeak,
        StScanLeft,
        StDone
    } find_bw_state_e;

endpackage

// File: rtl/find_bw_left_edge.sv
// Finds the spectral peak, then walks toward lower frequencies until the power
// drops THRESHOLD_DB below it; reports the straddling bin pair.
module find_bw_left_edge
    import find_bw_pkg::*;
#(
    parameter int unsigned ACCUM_WIDTH    = DefAccumWidth,
    parameter int unsigned FREQ_BIN_WIDTH = DefFreqBinWidth,
    parameter int          THRESHOLD_DB   = 7680,
    parameter int unsigned NUM_ACCUMS     = DefNumAccums
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic signed [ACCUM_WIDTH-1:0]    accumulator_val_i [NUM_ACCUMS],
    input  logic        [FREQ_BIN_WIDTH-1:0] freq_bin_i        [NUM_ACCUMS],
    output logic        [FREQ_BIN_WIDTH-1:0] f1_o,
    output logic        [FREQ_BIN_WIDTH-1:0] f2_o,
    output logic signed [ACCUM_WIDTH-1:0]    L1_o,
    output logic signed [ACCUM_WIDTH-1:0]    L2_o,
    output logic                             valid_o,
    output logic                             busy_o
);

    localparam int unsigned IdxW = (NUM_ACCUMS > 1) ? $clog2(NUM_ACCUMS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ACCUMS - 1);
    localparam logic signed [ACCUM_WIDTH:0] Thresh = (ACCUM_WIDTH+1)'(THRESHOLD_DB);

    find_bw_state_e state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] peak_q, peak_d;
    logic signed [ACCUM_WIDTH-1:0] max_q, max_d;
    logic [FREQ_BIN_WIDTH-1:0] f1_q, f1_d, f2_q, f2_d;
    logic signed [ACCUM_WIDTH-1:0] l1_q, l1_d, l2_q, l2_d;

    logic signed [ACCUM_WIDTH-1:0] cur_val;
    logic signed [ACCUM_WIDTH:0] cur_ext, max_ext, target;

    // One extra bit keeps peak - threshold from wrapping for very low peaks.
    assign cur_val = accumulator_val_i[idx_q];
    assign cur_ext = {cur_val[ACCUM_WIDTH-1], cur_val};
    assign max_ext = {max_q[ACCUM_WIDTH-1], max_q};
    assign target  = max_ext - Thresh;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        peak_d  = peak_q;
        max_d   = max_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFindPeak;
                    idx_d   = '0;
                end
            end
            StFindPeak: begin
                if (idx_q == '0 || cur_val > max_q) begin
                    max_d  = cur_val;
                    peak_d = idx_q;
                end
                if (idx_q == LastIdx) begin
                    if (peak_d == '0) begin
                        f1_d    = freq_bin_i[0];
                        f2_d    = freq_bin_i[0];
                        l1_d    = accumulator_val_i[0];
                        l2_d    = accumulator_val_i[0];
                        state_d = StDone;
                    end else begin
                        idx_d   = peak_d - IdxW'(1);
                        state_d = StScanLeft;
                    end
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StScanLeft: begin
                if (cur_ext <= target) begin
                    f1_d    = freq_bin_i[idx_q];
                    l1_d    = cur_val;
                    f2_d    = freq_bin_i[idx_q + IdxW'(1)];
                    l2_d    = accumulator_val_i[idx_q + IdxW'(1)];
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    f1_d    = freq_bin_i[0];
                    f2_d    = freq_bin_i[0];
                    l1_d    = accumulator_val_i[0];
                    l2_d    = accumulator_val_i[0];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            peak_q  <= '0;
            max_q   <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            peak_q  <= peak_d;
            max_q   <= max_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
        end
    end

    assign f1_o    = f1_q;
    assign f2_o    = f2_q;
    assign L1_o    = l1_q;
    assign L2_o    = l2_q;
    assign valid_o = (state_q == StDone);
    assign busy_o  = (state_q == StFindPeak) || (state_q == StScanLeft);

endmodule

// File: tb/tb_find_bw_left_edge.sv
// Self-checking bench: directed vector table, corner sequences, random vs model.
module tb_find_bw_left_edge;

    localparam int N   = 24;
    localparam int AW  = 18;
    localparam int FW  = 16;
    localparam int THR = 7680;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [AW-1:0] acc [N];
    logic        [FW-1:0] frq [N];
    logic        [FW-1:0] f1, f2;
    logic signed [AW-1:0] l1, l2;
    logic valid, busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    find_bw_left_edge dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .accumulator_val_i(acc),
        .freq_bin_i       (frq),
        .f1_o             (f1),
        .f2_o             (f2),
        .L1_o             (l1),
        .L2_o             (l2),
        .valid_o          (valid),
        .busy_o           (busy)
    );

    typedef struct {
        int pk_i; int pk_v; int base;
        int a_i;  int a_v;  int b_i; int b_v; int c_i; int c_v;
        int exp_f1; int exp_f2;
    } vec_t;

    vec_t vecs [9];

    function automatic void check(string name, longint act, longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Reference: first-occurrence maximum, then walk left for the first bin at
    // or below peak - THR; scanned = number of bins examined during the walk.
    task automatic model(output int f1i, output int f2i, output int scanned);
        int pk;
        int tgt;
        pk = 0;
        for (int i = 1; i < N; i++) if (acc[i] > acc[pk]) pk = i;
        tgt = int'(acc[pk]) - THR;
        f1i = 0;
        f2i = 0;
        scanned = pk;
        for (int i = pk - 1; i >= 0; i--) begin
            if (int'(acc[i]) <= tgt) begin
                f1i = i;
                f2i = i + 1;
                scanned = pk - i;
                break;
            end
        end
    endtask

    task automatic load_vec(input vec_t v, input int salt);
        for (int i = 0; i < N; i++) begin
            acc[i] = AW'(v.base);
            frq[i] = FW'(16'h1000 + i * 17 + salt * 3);
        end
        acc[v.pk_i] = AW'(v.pk_v);
        if (v.a_i >= 0) acc[v.a_i] = AW'(v.a_v);
        if (v.b_i >= 0) acc[v.b_i] = AW'(v.b_v);
        if (v.c_i >= 0) acc[v.c_i] = AW'(v.c_v);
    endtask

    task automatic run_search(input bit poke_start, output int lat, output int nvalid);
        lat = -1;
        nvalid = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int c = 1; c <= 2 * N + 8; c++) begin
            start = (poke_start && c == 5) ? 1'b1 : 1'b0;
            if (valid) begin
                nvalid++;
                if (lat < 0) lat = c;
                check("busy_low_in_done", busy, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_result(string tag, int f1i, int f2i, int scanned, int lat, int nvalid);
        check({tag, "_f1"}, f1, frq[f1i]);
        check({tag, "_f2"}, f2, frq[f2i]);
        check({tag, "_L1"}, l1, acc[f1i]);
        check({tag, "_L2"}, l2, acc[f2i]);
        check({tag, "_nvalid"}, nvalid, 1);
        check({tag, "_latency"}, lat, N + 1 + scanned);
    endtask

    initial begin
        int f1i, f2i, sc, lat, nv;
        vecs[0] = '{12, 0, -2560, 9, -7000, 8, -8000, -1, 0, 8, 9};
        vecs[1] = '{12, 0, -2560, 8, -7680, -1, 0, -1, 0, 8, 9};
        vecs[2] = '{5, 0, -2560, 15, 0, 2, -9000, 10, -9000, 2, 3};
        vecs[3] = '{0, 100, -2560, -1, 0, -1, 0, -1, 0, 0, 0};
        vecs[4] = '{12, 0, -2560, -1, 0, -1, 0, -1, 0, 0, 0};
        vecs[5] = '{3, 0, -2560, 0, -8000, -1, 0, -1, 0, 0, 1};
        vecs[6] = '{23, 0, -2560, 22, -7681, -1, 0, -1, 0, 22, 23};
        vecs[7] = '{7, -125000, -131072, -1, 0, -1, 0, -1, 0, 0, 0};
        vecs[8] = '{6, -20000, -30000, -1, 0, -1, 0, -1, 0, 5, 6};

        rst_n = 1'b0;
        start = 1'b0;
        load_vec(vecs[0], 0);
        repeat (2) @(negedge clk);
        check("reset_f1", f1, 0);
        check("reset_f2", f2, 0);
        check("reset_L1", l1, 0);
        check("reset_L2", l2, 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; expected indices are hand-derived, latency from model.
        for (int v = 0; v < 9; v++) begin
            load_vec(vecs[v], v);
            model(f1i, f2i, sc);
            run_search(1'b0, lat, nv);
            check_result($sformatf("vec%0d", v), vecs[v].exp_f1, vecs[v].exp_f2, sc, lat, nv);
        end

        // Start pulsed while busy must be ignored.
        load_vec(vecs[0], 11);
        model(f1i, f2i, sc);
        run_search(1'b1, lat, nv);
        check_result("restart_ignored", 8, 9, sc, lat, nv);

        // Reset during the left scan aborts without a valid pulse.
        load_vec(vecs[0], 12);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_f1", f1, 0);
        check("abort_f2", f2, 0);
        check("abort_L1", l1, 0);
        check("abort_L2", l2, 0);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 2 * N + 5; c++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        run_search(1'b0, lat, nv);
        check_result("after_abort", 8, 9, sc, lat, nv);

        // Random spectra against the reference model.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 3 == 0) acc[i] = AW'(int'($urandom_range(0, 262143)) - 131072);
                else acc[i] = AW'(int'($urandom_range(0, 14000)) - 12000);
                frq[i] = FW'($urandom_range(0, 65535));
            end
            if (t % 2 == 1) acc[$urandom_range(0, N - 1)] = AW'(int'($urandom_range(0, 3000)));
            model(f1i, f2i, sc);
            run_search(1'b0, lat, nv);
            check_result($sformatf("rand%0d", t), f1i, f2i, sc, lat, nv);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/find_bw_left_edge.md
FIND_BW_LEFT_EDGE -- requirements
Module: find_bw_left_edge

Interface
REQ-001 SHALL have parameter ACCUM_WIDTH, default 18: width of signed power values (Q-format dB, 8 fractional bits).
REQ-002 SHALL have parameter FREQ_BIN_WIDTH, default 16: width of unsigned frequency-bin labels.
REQ-003 SHALL have parameter THRESHOLD_DB, default 7680: positive drop below peak defining the edge (30.0 dB in Q8.8).
REQ-004 SHALL have parameter NUM_ACCUMS, default 24: number of spectral points.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_ni  in  1  async active-low reset.
REQ-008 start_i  in  1  start pulse.
REQ-009 accumulator_val_i  in  NUM_ACCUMS x ACCUM_WIDTH signed  power per bin, ascending frequency order.
REQ-010 freq_bin_i  in  NUM_ACCUMS x FREQ_BIN_WIDTH  frequency label per bin.
REQ-011 f1_o  out  FREQ_BIN_WIDTH  bin label at or below threshold (outer side of edge).
REQ-012 f2_o  out  FREQ_BIN_WIDTH  adjacent bin label above threshold (peak side).
REQ-013 L1_o  out  ACCUM_WIDTH signed  power at f1_o.
REQ-014 L2_o  out  ACCUM_WIDTH signed  power at f2_o.
REQ-015 valid_o  out  1  one-cycle result-ready pulse.
REQ-016 busy_o  out  1  high while a search is in progress.

Function
REQ-017 SHALL implement an FSM with states IDLE, FIND_PEAK, SCAN_LEFT, DONE.
REQ-018 IDLE: when start_i is sampled high, the FSM SHALL go to FIND_PEAK with index 0 and busy_o high from the next cycle.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 FIND_PEAK SHALL visit one bin per cycle, indices 0..NUM_ACCUMS-1.
REQ-021 FIND_PEAK SHALL keep the max value and its index, updating only on strictly greater values, so ties resolve to the lowest index.
REQ-022 After FIND_PEAK, the target SHALL be peak - THRESHOLD_DB, computed in ACCUM_WIDTH+1 bits with no overflow.
REQ-023 SCAN_LEFT SHALL start at peak_idx-1 and step down one index per cycle.
REQ-024 SCAN_LEFT SHALL stop at the first index i where accumulator_val_i[i] <= target (signed compare, ACCUM_WIDTH+1 bits).
REQ-025 On a hit, outputs SHALL be: f1_o=freq_bin_i[i], L1_o=accumulator_val_i[i], f2_o=freq_bin_i[i+1], L2_o=accumulator_val_i[i+1].
REQ-026 No-hit (index 0 passed without a hit, or peak_idx==0): f1_o=f2_o=freq_bin_i[0] and L1_o=L2_o=accumulator_val_i[0].
REQ-027 DONE SHALL assert valid_o for exactly one cycle, deassert busy_o, and return to IDLE.
REQ-028 Result outputs SHALL hold their values until overwritten by the next completed search.
REQ-029 Latency from start_i to valid_o SHALL be at most 2*NUM_ACCUMS+3 cycles.
REQ-030 Inputs SHALL be required stable while busy_o is high; the block SHALL NOT latch the full input arrays.

Reset
REQ-031 While rst_ni is low, the FSM SHALL be in IDLE and every output (f1_o, f2_o, L1_o, L2_o, valid_o, busy_o) SHALL be 0.
REQ-032 Reset asserted mid-search SHALL abort the search immediately, producing no valid_o.

Structure
REQ-033 The FSM state enum SHALL be defined in package find_bw_pkg.
REQ-034 Default widths ACCUM_WIDTH, FREQ_BIN_WIDTH and NUM_ACCUMS SHALL be defined in package find_bw_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; index width is $clog2(NUM_ACCUMS).

Verification
REQ-036 Peak 0 at index 12, bin[9]=-7000, bin[8]=-8000, all others -2560 -> f1=freq[8], L1=-8000 (0x3E0C0), f2=freq[9], L2=-7000, valid_o pulse.
REQ-037 Peak 0 at index 12, bin[8] exactly -7680 -> the hit is at index 8 (equality counts).
REQ-038 Equal peaks 0 at indices 5 and 15 -> scan starts from index 4.
REQ-039 Peak at index 0, or no bin <= target -> f1=f2=freq[0], L1=L2=accum[0], valid_o still pulses.
REQ-040 start_i pulsed again while busy_o is high -> ignored, exactly one valid_o.
REQ-041 rst_ni low mid-scan -> all outputs 0, no valid_o, next start_i runs normally.
